adjust_sequencer: RTL and testbench

- Control FSM for the masked S-box table-adjust datapath: five shares of 256-bit tables are re-indexed by an 8-bit mask (S[i] <= src[i ^ x]) under control of an enable and a 3-bit phase select.
- Obtains fresh masks x0..x3 from the RNG by handshake and issues the four adjust phases in order: phase 0 on the original tables, phases 1-3 on the recomputed S-box tables.
- Waits for the S-box stage between phases and flags each cycle in which adjusted tables are valid.
- Sits between the mask RNG, the S-box share pipeline and the adjust register bank.

---
 rtl/adjust_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_adjust_sequencer.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adjust_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : adjust_sequencer                                              |
// | Purpose  : Control FSM for the masked S-box table-adjust datapath.       |
// |            Fetches fresh masks x0..x3 from the RNG, issues the adjust    |
// |            phases in order, waits for the S-box stage between phases     |
// |            and flags the cycles in which adjusted tables are valid.      |
// | Ports    : clk, rst_n (async, active low), start, abort                  |
// |            mask_in/mask_valid/mask_ready : RNG mask handshake            |
// |            sb_valid                      : S-box tables ready            |
// |            adj_ctrl, adj_ctrl1           : adjust enable / phase select  |
// |            adj_x0..adj_x3                : latched masks                 |
// |            tbl_valid, tbl_phase          : adjusted tables valid / phase |
// |            busy, done, err               : status                        |
// |            rej_cnt                       : rejected-mask counter         |
// |                                            (ADJ_ZERO_MASK_CHECK_EN only) |
// | Options  : `define ADJ_ZERO_MASK_CHECK_EN to discard mask words that     |
// |            contain a zero byte.                                          |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module adjust_sequencer #(
  parameter int NUM_PHASES = 4,
  parameter int WAIT_MAX   = 64,
  parameter int TW         = 7
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] mask_in,
  input  logic        mask_valid,
  output logic        mask_ready,
  input  logic        sb_valid,
  output logic        adj_ctrl,
  output logic [2:0]  adj_ctrl1,
  output logic [7:0]  adj_x0,
  output logic [7:0]  adj_x1,
  output logic [7:0]  adj_x2,
  output logic [7:0]  adj_x3,
  output logic        tbl_valid,
  output logic [2:0]  tbl_phase,
  output logic        busy,
  output logic        done,
  output logic        err
`ifdef ADJ_ZERO_MASK_CHECK_EN
  ,
  output logic [7:0]  rej_cnt
`endif
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_ISSUE = 3'd2,
    S_CAPT  = 3'd3,
    S_WAIT  = 3'd4,
    S_DONE  = 3'd5,
    S_ERR   = 3'd6
  } state_t;

  localparam logic [2:0]    LAST_PHASE = 3'(NUM_PHASES - 1);
  localparam logic [TW-1:0] WAIT_LAST  = TW'(WAIT_MAX - 1);

  state_t        state;
  logic [2:0]    phase;
  logic [TW-1:0] timer;
  logic          mask_ok;

`ifdef ADJ_ZERO_MASK_CHECK_EN
  // A zero byte would leave one share unmasked, so such words are dropped.
  assign mask_ok = (mask_in[7:0] != 8'h00) && (mask_in[15:8] != 8'h00) &&
                   (mask_in[23:16] != 8'h00) && (mask_in[31:24] != 8'h00);
`else
  assign mask_ok = 1'b1;
`endif

  assign mask_ready = (state == S_REQ);
  assign busy       = (state != S_IDLE) && (state != S_ERR);

  // Pulse outputs are computed on the transition into the state they belong
  // to, so they are high exactly while the FSM sits in ISSUE / CAPT / DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      phase     <= 3'd0;
      timer     <= '0;
      adj_ctrl  <= 1'b0;
      adj_ctrl1 <= 3'd0;
      tbl_valid <= 1'b0;
      tbl_phase <= 3'd0;
      done      <= 1'b0;
      err       <= 1'b0;
      adj_x0    <= 8'h00;
      adj_x1    <= 8'h00;
      adj_x2    <= 8'h00;
      adj_x3    <= 8'h00;
`ifdef ADJ_ZERO_MASK_CHECK_EN
      rej_cnt   <= 8'h00;
`endif
    end else begin
      adj_ctrl  <= 1'b0;
      adj_ctrl1 <= 3'd0;
      tbl_valid <= 1'b0;
      tbl_phase <= 3'd0;
      done      <= 1'b0;

      if (abort) begin
        // Abort overrides everything, including a pending mask capture.
        state <= S_IDLE;
        err   <= 1'b0;
      end else begin
        case (state)
          S_IDLE, S_ERR: begin
            if (start) begin
              state <= S_REQ;
              err   <= 1'b0;
`ifdef ADJ_ZERO_MASK_CHECK_EN
              rej_cnt <= 8'h00;
`endif
            end
          end

          S_REQ: begin
            if (mask_valid) begin
              if (mask_ok) begin
                adj_x0    <= mask_in[7:0];
                adj_x1    <= mask_in[15:8];
                adj_x2    <= mask_in[23:16];
                adj_x3    <= mask_in[31:24];
                phase     <= 3'd0;
                adj_ctrl  <= 1'b1;
                adj_ctrl1 <= 3'd0;
                state     <= S_ISSUE;
              end
`ifdef ADJ_ZERO_MASK_CHECK_EN
              else if (rej_cnt != 8'hFF) begin
                rej_cnt <= rej_cnt + 8'd1;
              end
`endif
            end
          end

          S_ISSUE: begin
            // Adjust registers update one cycle after the enable pulse.
            tbl_valid <= 1'b1;
            tbl_phase <= phase;
            state     <= S_CAPT;
          end

          S_CAPT: begin
            if (phase == LAST_PHASE) begin
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              phase <= phase + 3'd1;
              timer <= '0;
              state <= S_WAIT;
            end
          end

          S_WAIT: begin
            // sb_valid wins over a coincident timeout.
            if (sb_valid) begin
              adj_ctrl  <= 1'b1;
              adj_ctrl1 <= phase;
              state     <= S_ISSUE;
            end else if (timer == WAIT_LAST) begin
              err   <= 1'b1;
              state <= S_ERR;
            end else begin
              timer <= timer + TW'(1);
            end
          end

          S_DONE:  state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_adjust_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_adjust_sequencer                                           |
// | Purpose  : Self-checking bench for adjust_sequencer: a timeline model    |
// |            predicts every output each cycle, plus directed scenarios     |
// |            with literal expectations. Honours ADJ_ZERO_MASK_CHECK_EN.    |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_adjust_sequencer;

  localparam int NUM_PHASES = 4;
  localparam int WAIT_MAX   = 64;
  localparam int TW         = 7;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, abort = 1'b0, mask_valid = 1'b0, sb_valid = 1'b0;
  logic [31:0] mask_in = 32'h0;
  logic        mask_ready, adj_ctrl, tbl_valid, busy, done, err;
  logic [2:0]  adj_ctrl1, tbl_phase;
  logic [7:0]  adj_x0, adj_x1, adj_x2, adj_x3;
`ifdef ADJ_ZERO_MASK_CHECK_EN
  logic [7:0]  rej_cnt;
`endif

  adjust_sequencer #(.NUM_PHASES(NUM_PHASES), .WAIT_MAX(WAIT_MAX), .TW(TW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .mask_in(mask_in), .mask_valid(mask_valid), .mask_ready(mask_ready),
    .sb_valid(sb_valid), .adj_ctrl(adj_ctrl), .adj_ctrl1(adj_ctrl1),
    .adj_x0(adj_x0), .adj_x1(adj_x1), .adj_x2(adj_x2), .adj_x3(adj_x3),
    .tbl_valid(tbl_valid), .tbl_phase(tbl_phase),
    .busy(busy), .done(done), .err(err)
`ifdef ADJ_ZERO_MASK_CHECK_EN
    , .rej_cnt(rej_cnt)
`endif
  );

  initial forever #5 clk = ~clk;

  int n_pass = 0, n_total = 0;
  bit check_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  // A run is a timeline: each triggered phase p contributes three fixed
  // future cycles (issue p, capture p, then done or an open-ended wait).
  localparam int K_ISSUE = 1, K_CAPT = 2, K_DONE = 3, K_WAIT = 4;
  int         m_cyc = 0;
  bit         m_busy = 0, m_req = 0, m_err = 0;
  int         m_last = 0, m_wait_from = -1, m_rej = 0;
  int         plan[$];
  logic [7:0] m_x[4] = '{8'h0, 8'h0, 8'h0, 8'h0};
  logic       e_ctrl = 0, e_tv = 0, e_done = 0;
  logic [2:0] e_ctrl1 = 0, e_tp = 0;

  function automatic bit has_zero(input logic [31:0] w);
    return (w[7:0] == 0) || (w[15:8] == 0) || (w[23:16] == 0) || (w[31:24] == 0);
  endfunction

  task automatic schedule(input int p);
    plan.push_back(K_ISSUE * 8 + p);
    plan.push_back(K_CAPT * 8 + p);
    plan.push_back(p == NUM_PHASES - 1 ? K_DONE * 8 : K_WAIT * 8);
  endtask

  initial forever begin
    int code;
    bit zero_rej;
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      plan.delete();
      m_busy = 0; m_req = 0; m_err = 0; m_wait_from = -1; m_rej = 0;
      for (int k = 0; k < 4; k++) m_x[k] = 8'h0;
      e_ctrl = 0; e_ctrl1 = 0; e_tv = 0; e_tp = 0; e_done = 0;
    end else begin
      m_cyc++;
      e_ctrl = 0; e_ctrl1 = 0; e_tv = 0; e_tp = 0; e_done = 0;
`ifdef ADJ_ZERO_MASK_CHECK_EN
      zero_rej = has_zero(mask_in);
`else
      zero_rej = 1'b0;
`endif
      if (abort) begin
        plan.delete();
        m_busy = 0; m_req = 0; m_err = 0; m_wait_from = -1;
      end else if (!m_busy) begin
        if (start) begin m_busy = 1; m_req = 1; m_err = 0; m_rej = 0; end
      end else if (m_req) begin
        if (mask_valid) begin
          if (zero_rej) begin
            if (m_rej < 255) m_rej++;
          end else begin
            for (int k = 0; k < 4; k++) m_x[k] = mask_in[8*k +: 8];
            m_req = 0;
            schedule(0);
          end
        end
      end else if (m_wait_from >= 0) begin
        if (sb_valid) begin
          m_wait_from = -1;
          schedule(m_last + 1);
        end else if (m_cyc - m_wait_from == WAIT_MAX) begin
          m_wait_from = -1; m_busy = 0; m_err = 1;
        end
      end
      if (m_busy && !m_req && m_wait_from < 0) begin
        if (plan.size() == 0) m_busy = 0;
        else begin
          code = plan.pop_front();
          case (code / 8)
            K_ISSUE: begin e_ctrl = 1; e_ctrl1 = 3'(code % 8); end
            K_CAPT:  begin e_tv = 1; e_tp = 3'(code % 8); m_last = code % 8; end
            K_DONE:  e_done = 1;
            default: m_wait_from = m_cyc;
          endcase
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(negedge clk);
    if (check_en) begin
      chk("outputs",
          64'({mask_ready, adj_ctrl, adj_ctrl1, tbl_valid, tbl_phase, busy, done, err}),
          64'({m_busy && m_req, e_ctrl, e_ctrl1, e_tv, e_tp, m_busy, e_done, m_err}));
      chk("masks", 64'({adj_x3, adj_x2, adj_x1, adj_x0}), 64'({m_x[3], m_x[2], m_x[1], m_x[0]}));
`ifdef ADJ_ZERO_MASK_CHECK_EN
      chk("rej_cnt", 64'(rej_cnt), 64'(m_rej));
`endif
    end
  end

  // ---------------- directed helpers ----------------
  int          w_nctrl, w_ntv, w_ndone, w_first_ctrl, w_first_tv, w_last_tv;
  int          w_done_at, w_err_at, w_abort_at, w_end;
  logic [11:0] w_seq;
  logic        w_ready1, w_err1;

  // Runs until busy drops (or bound expires). sb_valid answers on the second
  // WAIT cycle; optional abort on ISSUE of abort_phase; optional reset on the
  // first WAIT cycle after capture of rst_phase.
  task automatic watch(input int bound, input int abort_phase, input bit sb_en, input int rst_phase);
    int  since;
    bit  ended, rst_pending;
    w_nctrl = 0; w_ntv = 0; w_ndone = 0; w_first_ctrl = -1; w_first_tv = -1;
    w_last_tv = -1; w_done_at = -1; w_err_at = -1; w_abort_at = -1; w_end = -1;
    w_seq = 0; since = 99; ended = 0; rst_pending = 0;
    for (int i = 1; i <= bound; i++) begin
      @(negedge clk);
      start = 0; abort = 0;
      if (i == 1) begin w_ready1 = mask_ready; w_err1 = err; end
      if (rst_pending) begin
        #2 rst_n = 0;
        #1 chk("async_reset", 64'({mask_ready, adj_ctrl, adj_ctrl1, tbl_valid, tbl_phase, busy, done, err,
                                  adj_x3, adj_x2, adj_x1, adj_x0}), 64'(0));
        ended = 1; w_end = i; break;
      end
      if (adj_ctrl) begin
        w_nctrl++; w_seq = {w_seq[8:0], adj_ctrl1};
        if (w_first_ctrl < 0) w_first_ctrl = i;
        if (int'(adj_ctrl1) == abort_phase) begin abort = 1; w_abort_at = i; end
      end
      if (tbl_valid) begin
        w_ntv++; w_last_tv = i;
        if (w_first_tv < 0) w_first_tv = i;
        if (int'(tbl_phase) == rst_phase) rst_pending = 1;
      end
      if (done) begin w_ndone++; w_done_at = i; end
      if (err && w_err_at < 0) w_err_at = i;
      since = tbl_valid ? 0 : since + 1;
      sb_valid = sb_en && (since == 2);
      if (!busy && i > 1) begin ended = 1; w_end = i; break; end
    end
    sb_valid = 0;
    chk("watch_bound", 64'(ended), 64'(1));
  endtask

  task automatic kick(input logic [31:0] m);
    @(negedge clk);
    start = 1; mask_in = m; mask_valid = 1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int ready_cnt;
    repeat (2) @(negedge clk);
    #2 rst_n = 1;
    @(negedge clk);
    check_en = 1;
    chk("reset_state", 64'({mask_ready, adj_ctrl, adj_ctrl1, tbl_valid, tbl_phase, busy, done, err,
                           adj_x3, adj_x2, adj_x1, adj_x0}), 64'(0));

    // Full run with mask already valid.
    kick(32'h1F2E3D4C);
    watch(100, -1, 1, -1);
    chk("lat_first_ctrl", 64'(w_first_ctrl), 64'(2));
    chk("lat_first_tv", 64'(w_first_tv), 64'(3));
    chk("x0", 64'(adj_x0), 64'(8'h4C));
    chk("x3", 64'(adj_x3), 64'(8'h1F));
    chk("ctrl1_seq", 64'(w_seq), 64'(12'b000_001_010_011));
    chk("n_ctrl", 64'(w_nctrl), 64'(4));
    chk("n_tv", 64'(w_ntv), 64'(4));
    chk("n_done", 64'(w_ndone), 64'(1));
    chk("done_after_capt", 64'(w_done_at - w_last_tv), 64'(1));
    chk("busy_fall", 64'(w_end - w_done_at), 64'(1));

    // Timeout: no sb_valid after phase 0.
    kick(32'h01020304);
    watch(200, -1, 0, -1);
    chk("to_n_ctrl", 64'(w_nctrl), 64'(1));
    chk("to_err_delay", 64'(w_err_at - w_last_tv), 64'(65));
    chk("to_err", 64'(err), 64'(1));
    @(negedge clk); start = 1;
    watch(100, -1, 1, -1);
    chk("err_restart_ready", 64'(w_ready1), 64'(1));
    chk("err_restart_clear", 64'(w_err1), 64'(0));
    chk("err_restart_done", 64'(w_ndone), 64'(1));

    // Abort during ISSUE of phase 2.
    kick(32'h11223344);
    watch(100, 2, 1, -1);
    chk("ab_n_ctrl", 64'(w_nctrl), 64'(3));
    chk("ab_seq", 64'(w_seq[8:0]), 64'(9'b000_001_010));
    chk("ab_idle_next", 64'(w_end - w_abort_at), 64'(1));
    chk("ab_no_done", 64'(w_ndone), 64'(0));
    repeat (5) @(negedge clk);
    chk("ab_quiet", 64'({adj_ctrl, busy, done}), 64'(0));

    // Mask delayed after start.
    @(negedge clk); start = 1; mask_valid = 0; mask_in = 32'hA5A55A5A;
    ready_cnt = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      start = 0;
      if (mask_ready && !adj_ctrl) ready_cnt++;
      if (i == 10) mask_valid = 1;
    end
    watch(100, -1, 1, -1);
    chk("dly_ready_cycles", 64'(ready_cnt), 64'(10));
    chk("dly_first_ctrl", 64'(w_first_ctrl), 64'(1));
    chk("dly_done", 64'(w_ndone), 64'(1));

`ifdef ADJ_ZERO_MASK_CHECK_EN
    kick(32'h00112233);
    @(negedge clk); start = 0;
    @(negedge clk); mask_in = 32'hAABBCCDD;
    chk("zc_still_ready", 64'(mask_ready), 64'(1));
    chk("zc_rej1", 64'(rej_cnt), 64'(1));
    watch(100, -1, 1, -1);
    chk("zc_x0", 64'(adj_x0), 64'(8'hDD));
    chk("zc_rej_final", 64'(rej_cnt), 64'(1));
`endif

    // Reset during WAIT of phase 1, then a clean run.
    kick(32'h5C6D7E8F);
    watch(100, -1, 1, 1);
    chk("rst_no_done", 64'(w_ndone), 64'(0));
    @(negedge clk); #2 rst_n = 1;
    kick(32'h13579BDF);
    watch(100, -1, 1, -1);
    chk("post_rst_ctrl", 64'(w_nctrl), 64'(4));
    chk("post_rst_done", 64'(w_ndone), 64'(1));
    chk("post_rst_x1", 64'(adj_x1), 64'(8'h9B));

    // Randomized traffic; the model checks every cycle.
    for (int i = 0; i < 3000; i++) begin
      bit quiet;
      @(negedge clk);
      quiet = ((i / 400) % 3) == 2;
      start      = ($urandom % 8) == 0;
      abort      = !quiet && (($urandom % 64) == 0);
      mask_valid = ($urandom % 3) != 0;
      mask_in    = $urandom;
      if (($urandom % 4) == 0) mask_in[8 * ($urandom % 4) +: 8] = 8'h00;
      sb_valid   = !quiet && (($urandom % 6) == 0);
      if (($urandom % 500) == 0) begin
        #2 rst_n = 0;
        #2 rst_n = 1;
      end
    end
    @(negedge clk);
    start = 0; abort = 0; mask_valid = 0; sb_valid = 0;
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
